aes_round_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 encryption datapath: the shared state register, the round-function chain (subbytes/shiftrows/mixcolumns/addroundkey) and the on-the-fly key expander. It accepts one block per valid/ready handshake and drives load enables, mux selects, round index, last-round flag and round constant for NR consecutive round cycles. It then holds the result valid until the consumer accepts it. It has no datapath of its own; it sits between the block-level handshake and the 128-bit round datapath.

---
 rtl/aes_round_ctrl_if.sv | 30 +++
 rtl/aes_round_ctrl.sv | 90 +++++++++
 tb/tb_aes_round_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Block handshake plus round-datapath control bundle shared by the AES round controller
// (slave side) and the environment that feeds blocks and drains ciphertexts (master side).
interface aes_round_ctrl_if #(
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          st_ld_en;
    logic          st_sel;
    logic          key_ld_en;
    logic          key_sel;
    logic [RW-1:0] round;
    logic          last_round;
    logic [7:0]    rcon;
    logic          busy;

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, st_ld_en, st_sel, key_ld_en, key_sel,
               round, last_round, rcon, busy
    );

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, st_ld_en, st_sel, key_ld_en, key_sel,
               round, last_round, rcon, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES-128 datapath: accepts a block, runs NR round cycles with
// load enables, mux selects and round constants, then holds the ciphertext until taken.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic            clk,
    input  logic            reset,
    aes_round_ctrl_if.slave bus
);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_ROUND = 2'd1;
    localparam logic [1:0]    S_DONE  = 2'd2;
    localparam logic [RW-1:0] LAST    = RW'(NR);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [7:0]    rcon_q, rcon_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rcon_d         = rcon_q;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.busy       = 1'b0;
        bus.st_ld_en   = 1'b0;
        bus.st_sel     = 1'b0;
        bus.key_ld_en  = 1'b0;
        bus.key_sel    = 1'b0;
        bus.round      = '0;
        bus.last_round = 1'b0;
        bus.rcon       = 8'h00;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                // The accept cycle itself loads plaintext^key and the cipher key.
                if (bus.in_valid) begin
                    bus.st_ld_en  = 1'b1;
                    bus.key_ld_en = 1'b1;
                    state_d       = S_ROUND;
                    cnt_d         = RW'(1);
                    rcon_d        = 8'h01;
                end
            end
            S_ROUND: begin
                bus.busy       = 1'b1;
                bus.st_ld_en   = 1'b1;
                bus.st_sel     = 1'b1;
                bus.key_ld_en  = 1'b1;
                bus.key_sel    = 1'b1;
                bus.round      = cnt_q;
                bus.last_round = (cnt_q == LAST);
                bus.rcon       = rcon_q;
                cnt_d          = cnt_q + RW'(1);
                rcon_d         = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    rcon_d  = 8'h01;
                end
            end
            S_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rcon_d  = 8'h01;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an NR=10 and an NR=1 instance share random handshake inputs; a
// cycle-level model and a software AES-128 datapath judge every output and ciphertext.
module tb_aes_round_ctrl;
    localparam int NR  = 10;
    localparam int RW  = 4;
    localparam int NR1 = 1;
    localparam int RW1 = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         outReady;
    logic [127:0] ptIn;
    logic [127:0] keyIn;

    aes_round_ctrl_if #(.RW(RW))  bus0 ();
    aes_round_ctrl_if #(.RW(RW1)) bus1 ();

    assign bus0.in_valid  = inValid;
    assign bus0.out_ready = outReady;
    assign bus1.in_valid  = inValid;
    assign bus1.out_ready = outReady;

    aes_round_ctrl #(.NR(NR),  .RW(RW))  dut    (.clk(clk), .reset(reset), .bus(bus0));
    aes_round_ctrl #(.NR(NR1), .RW(RW1)) dutOne (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    int           vectors      = 0;
    int           miscompares  = 0;
    int           cipherChecks = 0;
    int           cycle        = 0;
    int           seenAccepts  = 0;
    int           ph0          = 0;
    int           ph1          = 0;
    bit           recordOn     = 1'b0;
    int           oneRounds    = 0;
    int           oneLasts     = 0;
    logic [7:0]   sboxTab [256];
    logic [7:0]   rconLit [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0]   rconSeen [$];
    int           roundSeen [$];
    bit           lastSeen [$];
    int           acceptCycles [$];
    logic [127:0] expQ [$];
    logic [127:0] lastCipher;
    logic [127:0] dpState;
    logic [127:0] dpKey;

    // GF(2^8) arithmetic: carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] rconOf(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
            end
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sboxTab[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
        w0 ^= t;
        w1 ^= w0;
        w2 ^= w1;
        w3 ^= w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] roundFn(input logic [127:0] s, input logic [127:0] rk, input logic last);
        return (last ? subShift(s) : mixCols(subShift(s))) ^ rk;
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [127:0] s, k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= nr; r++) begin
            k = nextKey(k, rconOf(r));
            s = roundFn(s, k, r == nr);
        end
        return s;
    endfunction

    // Elapsed-cycle view of one block: 0 idle, 1..n round index, n+1 waiting for the consumer.
    function automatic int nextPh(input int p, input int n);
        if (p == 0) return inValid ? 1 : 0;
        if (p <= n) return p + 1;
        return outReady ? 0 : p;
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, k, cycle, act, exp);
        end
    endtask

    task automatic compareInst(input int k, input int p, input int n,
                               input logic inRdy, input logic outV, input logic bsy,
                               input logic stLd, input logic stSel, input logic keyLd, input logic keySel,
                               input logic [31:0] rnd, input logic last, input logic [7:0] rc);
        bit idle, inRound, done;
        idle    = (p == 0);
        inRound = (p >= 1) && (p <= n);
        done    = (p == n + 1);
        checkOutput("in_ready",   k, 128'(inRdy),  128'(idle));
        checkOutput("out_valid",  k, 128'(outV),   128'(done));
        checkOutput("busy",       k, 128'(bsy),    128'(inRound || done));
        checkOutput("st_ld_en",   k, 128'(stLd),   128'(inRound || (idle && inValid)));
        checkOutput("st_sel",     k, 128'(stSel),  128'(inRound));
        checkOutput("key_ld_en",  k, 128'(keyLd),  128'(inRound || (idle && inValid)));
        checkOutput("key_sel",    k, 128'(keySel), 128'(inRound));
        checkOutput("round",      k, 128'(rnd),    inRound ? 128'(p) : 128'(0));
        checkOutput("last_round", k, 128'(last),   128'(inRound && (p == n)));
        checkOutput("rcon",       k, 128'(rc),     inRound ? 128'(rconOf(p)) : 128'(0));
    endtask

    task automatic checkCipher();
        cipherChecks++;
        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ciphertext at cycle %0d: got %0h, expected no pending block", cycle, dpState);
        end else begin
            checkOutput("ciphertext", 0, dpState, expQ[0]);
        end
    endtask

    task automatic recordRounds();
        if (bus0.busy && bus0.st_sel) begin
            rconSeen.push_back(bus0.rcon);
            roundSeen.push_back(int'(bus0.round));
            lastSeen.push_back(bus0.last_round);
        end
        if (bus1.busy && bus1.st_sel) begin
            oneRounds++;
            if (bus1.last_round && bus1.round == RW1'(1)) oneLasts++;
        end
    endtask

    task automatic applyStimulus(input bit v, input bit r, input int n);
        inValid  = v;
        outReady = r;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (acceptCycles.size() != seenAccepts) begin
                seenAccepts = acceptCycles.size();
                ptIn  = {$urandom, $urandom, $urandom, $urandom};
                keyIn = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Software copy of the 128-bit datapath, steered only by the controller's outputs.
    always @(posedge clk) begin
        if (bus0.key_ld_en) dpKey <= bus0.key_sel ? nextKey(dpKey, bus0.rcon) : keyIn;
        if (bus0.st_ld_en)
            dpState <= bus0.st_sel ? roundFn(dpState, nextKey(dpKey, bus0.rcon), bus0.last_round)
                                   : ptIn ^ keyIn;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph0 <= 0;
            ph1 <= 0;
            expQ.delete();
        end else begin
            ph0 <= nextPh(ph0, NR);
            ph1 <= nextPh(ph1, NR1);
            if (ph0 == 0 && inValid) begin
                expQ.push_back(aesEncrypt(ptIn, keyIn, NR));
                acceptCycles.push_back(cycle);
            end
            if (ph0 == NR + 1 && outReady) begin
                lastCipher <= dpState;
                if (expQ.size() != 0) expQ.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        compareInst(0, ph0, NR, bus0.in_ready, bus0.out_valid, bus0.busy, bus0.st_ld_en, bus0.st_sel,
                    bus0.key_ld_en, bus0.key_sel, 32'(bus0.round), bus0.last_round, bus0.rcon);
        compareInst(1, ph1, NR1, bus1.in_ready, bus1.out_valid, bus1.busy, bus1.st_ld_en, bus1.st_sel,
                    bus1.key_ld_en, bus1.key_sel, 32'(bus1.round), bus1.last_round, bus1.rcon);
        if (!reset && ph0 == NR + 1 && outReady) checkCipher();
        if (recordOn) recordRounds();
    end

    initial begin
        int  n0;
        int  c0;
        bit  found;

        buildSbox();
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        ptIn     = 128'h00112233445566778899aabbccddeeff;
        keyIn    = 128'h000102030405060708090a0b0c0d0e0f;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  0, 128'(bus0.in_ready),   128'(1));
        checkOutput("rst_out_valid", 0, 128'(bus0.out_valid),  128'(0));
        checkOutput("rst_busy",      0, 128'(bus0.busy),       128'(0));
        checkOutput("rst_round",     0, 128'(bus0.round),      128'(0));
        checkOutput("rst_rcon",      0, 128'(bus0.rcon),       128'(0));
        reset = 1'b0;

        $display("[TB] FIPS-197 block with rcon/round trace");
        recordOn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, NR + 3);
        recordOn = 1'b0;
        checkOutput("fips_cipher", 0, lastCipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("rcon_count",  0, 128'(rconSeen.size()), 128'(10));
        for (int i = 0; i < rconSeen.size() && i < 10; i++) begin
            checkOutput("rcon_seq",  i, 128'(rconSeen[i]),  128'(rconLit[i]));
            checkOutput("round_seq", i, 128'(roundSeen[i]), 128'(i + 1));
            checkOutput("last_seq",  i, 128'(lastSeen[i]),  128'(i == 9));
        end
        checkOutput("nr1_rounds", 1, 128'(oneRounds), 128'(1));
        checkOutput("nr1_last",   1, 128'(oneLasts),  128'(1));

        $display("[TB] backpressure for 20 cycles");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, NR + 1 + 20);
        applyStimulus(1'b0, 1'b1, 3);

        $display("[TB] in_valid held through ROUND and DONE");
        n0 = acceptCycles.size();
        applyStimulus(1'b1, 1'b1, 3 * (NR + 2) + 1);
        checkOutput("accept_count", 0, 128'(acceptCycles.size() - n0), 128'(4));
        for (int i = n0 + 1; i < acceptCycles.size(); i++)
            checkOutput("accept_gap", i, 128'(acceptCycles[i] - acceptCycles[i-1]), 128'(NR + 2));
        applyStimulus(1'b0, 1'b1, NR + 4);

        $display("[TB] reset pulse in round 5");
        applyStimulus(1'b1, 1'b1, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus0.round == RW'(5)) found = 1'b1;
            else applyStimulus(1'b0, 1'b1, 1);
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_round5: got no round 5 within 40 cycles, expected round 5");
        end
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready",  0, 128'(bus0.in_ready),   128'(1));
        checkOutput("mid_rst_busy",      0, 128'(bus0.busy),       128'(0));
        checkOutput("mid_rst_st_ld_en",  0, 128'(bus0.st_ld_en),   128'(0));
        checkOutput("mid_rst_round",     0, 128'(bus0.round),      128'(0));
        checkOutput("mid_rst_last",      0, 128'(bus0.last_round), 128'(0));
        checkOutput("mid_rst_rcon",      0, 128'(bus0.rcon),       128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        c0 = cipherChecks;
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, NR + 3);
        checkOutput("post_reset_blocks", 0, 128'(cipherChecks - c0), 128'(1));

        $display("[TB] randomized handshake traffic");
        for (int i = 0; i < 3000; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1);
        applyStimulus(1'b0, 1'b1, NR + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
